// File: rtl/pipe_stage_buffer_pkg.sv
// Shared definitions for the pipeline stage buffer: skid FSM states and the debug fill pattern.
// The fill helper widens the 32-bit pattern so any payload width up to FILL_MAX_W can slice it.
package pipe_stage_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam logic [31:0] PIPE_DEBUG_FILL = 32'h2A2A_2A2A;
    localparam int          FILL_MAX_W      = 1024;

    // Repeats the pattern from the LSB upward; callers keep the low DATA_W bits,
    // so a payload that is not a multiple of 32 loses the pattern's MSB end.
    function automatic logic [FILL_MAX_W-1:0] replicate_fill(input logic [31:0] pattern);
        logic [FILL_MAX_W-1:0] result;
        result = '0;
        for (int i = 0; i < FILL_MAX_W / 32; i++) begin
            result[i*32 +: 32] = pattern;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_stage_buffer_slot.sv
// One held pipeline entry: valid bit, state-changing control bits and payload.
// Reset/flush and consume both drop the control bits so a bubble can never carry an enable.
module pipe_slot #(
    parameter int                CTRL_W = 8,
    parameter int                DATA_W = 128,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: state is updated with non-blocking assignments so every slot samples
    // its neighbours' pre-edge values; this is what makes main <= skid a clean shift.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= FILL;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= load_ctrl;
            data  <= load_data;
        end else if (clear) begin
            // Payload is deliberately kept; only the valid and enables go away.
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Parametrised pipeline stage register with valid/ready handshake, synchronous flush
// and an optional second (skid) entry that turns In_Ready into a registered signal.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int          CTRL_W     = 8,
    parameter int          DATA_W     = 128,
    parameter int          SKID_EN    = 0,
    parameter logic [31:0] DEBUG_FILL = PIPE_DEBUG_FILL
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    localparam logic [FILL_MAX_W-1:0] FILL_FULL = replicate_fill(DEBUG_FILL);
    localparam logic [DATA_W-1:0]     FILL      = FILL_FULL[DATA_W-1:0];

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              in_fire;
    logic              out_fire;

    // Outputs come straight from the main entry register: no In->Out combinational path.
    assign Out_Valid = main_valid;
    assign Out_Ctrl  = main_ctrl;
    assign Out_Data  = main_data;

    assign in_fire  = In_Valid & In_Ready;
    assign out_fire = main_valid & Out_Ready;

    generate
        if (SKID_EN == 0) begin : g_single
            logic main_load;
            logic main_clear;

            // A new entry may replace the head in the same cycle it leaves.
            assign In_Ready   = ~main_valid | Out_Ready;
            assign main_load  = in_fire;
            assign main_clear = out_fire & ~in_fire;
            assign Occupancy  = {1'b0, main_valid};

            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W),
                .FILL   (FILL)
            ) u_main (
                .clk       (CLK),
                .rst       (RST),
                .flush     (Flush),
                .load      (main_load),
                .clear     (main_clear),
                .load_ctrl (In_Ctrl),
                .load_data (In_Data),
                .valid     (main_valid),
                .ctrl      (main_ctrl),
                .data      (main_data)
            );
        end else begin : g_skid
            skid_state_t       state;
            skid_state_t       state_next;
            logic              in_ready_q;
            logic              main_load;
            logic              main_clear;
            logic              main_from_skid;
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] main_ctrl_in;
            logic [DATA_W-1:0] main_data_in;

            // NOTE: every output of this block is given a default first, so no path
            // through the case statement can leave a value held and infer a latch.
            always_comb begin
                state_next     = state;
                main_load      = 1'b0;
                main_clear     = 1'b0;
                main_from_skid = 1'b0;
                skid_load      = 1'b0;
                skid_clear     = 1'b0;
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            state_next = ONE;
                            main_load  = 1'b1;
                        end
                    end
                    ONE: begin
                        if (in_fire && !out_fire) begin
                            state_next = TWO;
                            skid_load  = 1'b1;
                        end else if (out_fire && !in_fire) begin
                            state_next = EMPTY;
                            main_clear = 1'b1;
                        end else if (in_fire && out_fire) begin
                            main_load = 1'b1;
                        end
                    end
                    TWO: begin
                        // In_Ready is low here, so only the drain can happen.
                        if (out_fire) begin
                            state_next     = ONE;
                            main_load      = 1'b1;
                            main_from_skid = 1'b1;
                            skid_clear     = 1'b1;
                        end
                    end
                    default: state_next = EMPTY;
                endcase
            end

            always_ff @(posedge CLK) begin
                if (RST || Flush) begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state      <= state_next;
                    in_ready_q <= (state_next != TWO);
                end
            end

            assign In_Ready     = in_ready_q;
            assign main_ctrl_in = main_from_skid ? skid_ctrl : In_Ctrl;
            assign main_data_in = main_from_skid ? skid_data : In_Data;
            assign Occupancy    = 2'(main_valid) + 2'(skid_valid);

            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W),
                .FILL   (FILL)
            ) u_main (
                .clk       (CLK),
                .rst       (RST),
                .flush     (Flush),
                .load      (main_load),
                .clear     (main_clear),
                .load_ctrl (main_ctrl_in),
                .load_data (main_data_in),
                .valid     (main_valid),
                .ctrl      (main_ctrl),
                .data      (main_data)
            );

            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W),
                .FILL   (FILL)
            ) u_skid (
                .clk       (CLK),
                .rst       (RST),
                .flush     (Flush),
                .load      (skid_load),
                .clear     (skid_clear),
                .load_ctrl (In_Ctrl),
                .load_data (In_Data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Drives one single-entry and one skid instance with shared stimulus and compares both
// against a FIFO model with capacity 1 or 2 that only knows the handshake rules.
module tb_pipe_stage_buffer;

    localparam int           CTRL_W = 8;
    localparam int           DATA_W = 128;
    localparam logic [127:0] FILL   = {4{32'h2A2A_2A2A}};

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;

    logic [1:0]             in_ready;
    logic [1:0]             out_valid;
    logic [1:0][CTRL_W-1:0] out_ctrl;
    logic [1:0][DATA_W-1:0] out_data;
    logic [1:0][1:0]        occupancy;

    pipe_stage_buffer #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(0), .DEBUG_FILL(32'h2A2A_2A2A)
    ) dut0 (
        .CLK(clk), .RST(rst), .Flush(flush),
        .In_Valid(in_valid), .In_Ready(in_ready[0]), .In_Ctrl(in_ctrl), .In_Data(in_data),
        .Out_Valid(out_valid[0]), .Out_Ready(out_ready), .Out_Ctrl(out_ctrl[0]),
        .Out_Data(out_data[0]), .Occupancy(occupancy[0])
    );

    pipe_stage_buffer #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(1), .DEBUG_FILL(32'h2A2A_2A2A)
    ) dut1 (
        .CLK(clk), .RST(rst), .Flush(flush),
        .In_Valid(in_valid), .In_Ready(in_ready[1]), .In_Ctrl(in_ctrl), .In_Data(in_data),
        .Out_Valid(out_valid[1]), .Out_Ready(out_ready), .Out_Ctrl(out_ctrl[1]),
        .Out_Data(out_data[1]), .Occupancy(occupancy[1])
    );

    // Model: per instance an ordered list of held entries (index 0 = head).
    entry_t mq    [2][2];
    int     mcnt  [2];
    bit     mfresh[2];
    int     n_vec  = 0;
    int     n_miss = 0;

    function automatic bit model_ready(input int k);
        if (k == 0) return (mcnt[k] == 0) || out_ready;
        return mcnt[k] < 2;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_models();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d in_ready", k), 128'(in_ready[k]), 128'(model_ready(k)));
            check($sformatf("dut%0d out_valid", k), 128'(out_valid[k]), 128'(mcnt[k] > 0));
            check($sformatf("dut%0d occupancy", k), 128'(occupancy[k]), 128'(mcnt[k]));
            check($sformatf("dut%0d out_ctrl", k), 128'(out_ctrl[k]),
                  (mcnt[k] > 0) ? 128'(mq[k][0].ctrl) : 128'd0);
            if (mcnt[k] > 0)
                check($sformatf("dut%0d out_data", k), out_data[k], mq[k][0].data);
            else if (mfresh[k])
                check($sformatf("dut%0d fill", k), out_data[k], FILL);
            n_vec++;
            assert (out_valid[k] === 1'b1 || out_ctrl[k] === '0) else begin
                n_miss++;
                $error("FAIL dut%0d bubble_ctrl: observed %0h, required 0", k, out_ctrl[k]);
            end
        end
    endtask

    // Entered and left at a falling edge with inputs already driven.
    task automatic step(input bit chk);
        bit ifire[2];
        bit ofire[2];
        bit clr;
        #1;
        if (chk) compare_models();
        clr = rst || flush;
        for (int k = 0; k < 2; k++) begin
            ifire[k] = in_valid && model_ready(k);
            ofire[k] = (mcnt[k] > 0) && out_ready;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                mcnt[k]   = 0;
                mfresh[k] = 1'b1;
            end else begin
                if (ofire[k]) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (ifire[k]) begin
                    mq[k][mcnt[k]] = {in_ctrl, in_data};
                    mcnt[k]++;
                    mfresh[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] da, db, dc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_ctrl = 8'h5A; in_data = '1;
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mfresh[k] = 1'b1;
        end
        @(negedge clk);

        // Reset held for two cycles with a valid input present.
        step(1'b0);
        step(1'b0);
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst dut%0d out_valid", k), 128'(out_valid[k]), 128'd0);
            check($sformatf("rst dut%0d out_ctrl", k), 128'(out_ctrl[k]), 128'd0);
            check($sformatf("rst dut%0d out_data", k), out_data[k], FILL);
            check($sformatf("rst dut%0d occupancy", k), 128'(occupancy[k]), 128'd0);
            check($sformatf("rst dut%0d in_ready", k), 128'(in_ready[k]), 128'd1);
        end

        // Back-to-back stream: each entry appears one cycle after it is offered.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 8'(i + 1);
            in_data  = {4{32'hC0DE_0000 + 32'(i)}};
            step(1'b1);
            check("stream data", out_data[0], in_data);
            check("stream occupancy", 128'(occupancy[0]), 128'd1);
        end
        in_valid = 1'b0;
        step(1'b1);
        step(1'b1);

        // Stall with skid: A and B fill both entries, C waits upstream.
        da = {4{32'hAAAA_0001}}; db = {4{32'hBBBB_0002}}; dc = {4{32'hCCCC_0003}};
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h11; in_data = da; step(1'b1);
        in_ctrl = 8'h22; in_data = db; step(1'b1);
        in_ctrl = 8'h33; in_data = dc;
        check("stall occupancy", 128'(occupancy[1]), 128'd2);
        check("stall in_ready", 128'(in_ready[1]), 128'd0);
        check("stall head A", out_data[1], da);
        step(1'b1);
        check("stall still full", 128'(occupancy[1]), 128'd2);
        out_ready = 1'b1;
        step(1'b1);
        check("drain B", out_data[1], db);
        check("drain B ctrl", 128'(out_ctrl[1]), 128'h22);
        step(1'b1);
        check("drain C", out_data[1], dc);
        check("drain C ctrl", 128'(out_ctrl[1]), 128'h33);
        in_valid = 1'b0;
        step(1'b1);
        check("drained empty", 128'(out_valid[1]), 128'd0);

        // Flush while full and mid-handshake.
        out_ready = 1'b0; in_valid = 1'b1;
        in_ctrl = 8'h44; in_data = {4{32'hDDDD_0004}}; step(1'b1);
        in_ctrl = 8'h55; in_data = {4{32'hEEEE_0005}}; step(1'b1);
        check("pre-flush occupancy", 128'(occupancy[1]), 128'd2);
        flush = 1'b1; out_ready = 1'b1; in_ctrl = 8'h66; in_data = {4{32'hFFFF_0006}};
        step(1'b1);
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("flush dut%0d out_valid", k), 128'(out_valid[k]), 128'd0);
            check($sformatf("flush dut%0d out_ctrl", k), 128'(out_ctrl[k]), 128'd0);
            check($sformatf("flush dut%0d occupancy", k), 128'(occupancy[k]), 128'd0);
            check($sformatf("flush dut%0d out_data", k), out_data[k], FILL);
        end
        check("flush in_ready", 128'(in_ready[1]), 128'd1);

        // Single entry: head replaced while it leaves, all-ones ctrl passes untouched.
        out_ready = 1'b1; in_valid = 1'b1;
        in_ctrl = 8'hFF; in_data = {4{32'h1234_5678}}; step(1'b1);
        in_ctrl = 8'hFF; in_data = {4{32'h8765_4321}};
        #1;
        check("simul in_ready", 128'(in_ready[0]), 128'd1);
        check("simul out_valid", 128'(out_valid[0]), 128'd1);
        step(1'b1);
        check("simul data", out_data[0], {4{32'h8765_4321}});
        check("simul ctrl", 128'(out_ctrl[0]), 128'hFF);
        check("simul occupancy", 128'(occupancy[0]), 128'd1);
        in_valid = 1'b0;
        step(1'b1);

        // Constrained-random valid/ready/flush/reset.
        for (int n = 0; n < 10000; n++) begin
            rst       = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_ctrl   = 8'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1);
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
